addr_map_cfg: RTL and testbench

Runtime configuration controller for a combinational address decoder's rule array.
- Software or a config master writes rules one at a time into a shadow array.
- A commit request triggers a multi-cycle validation sequence: one rule per cycle, then one rule pair per cycle.
- Only a fully valid shadow map is atomically copied to the active map that drives the decoder, so a half-written or illegal map is never visible downstream.

---
 rtl/addr_map_cfg_pkg.sv | 39 +++
 rtl/addr_map_rule_check.sv | 34 +++
 rtl/addr_map_cfg.sv | 189 ++++++++++++++++++
 tb/tb_addr_map_cfg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_map_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_cfg_pkg
// Description : Shared types and helpers for the address-map configuration
//               controller. It provides the address and rule types, the
//               controller state encoding, the slot-index width helper and
//               the rule-pair count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_map_cfg_pkg;

  typedef logic [31:0] addr_t;

  // One decoder rule: the half-open range [start_addr, end_addr) maps to idx.
  typedef struct packed {
    int unsigned idx;
    addr_t       start_addr;
    addr_t       end_addr;
  } rule_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHK_RULE = 2'd1,
    CHK_PAIR = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Width needed to index n entries; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of distinct rule pairs (i<j) the overlap scan visits.
  function automatic int unsigned num_pairs(input int unsigned n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_map_rule_check.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_rule_check
// Description : Combinational rule checker shared by every validation step.
//   rule_a_i  : rule under test / first rule of a pair
//   rule_b_i  : second rule of a pair (only the address range is used)
//   rule_ok_o : rule_a_i has start < end and a legal target index
//   overlap_o : the ranges of rule_a_i and rule_b_i intersect
// Revision    : 1.0 - initial release
// ============================================================================
module addr_map_rule_check
  import addr_map_cfg_pkg::*;
#(
  parameter int unsigned NoIndices = 4
) (
  input  rule_t rule_a_i,
  input  rule_t rule_b_i,
  output logic  rule_ok_o,
  output logic  overlap_o
);

  logic w_unused_idx_b;

  assign rule_ok_o = (rule_a_i.start_addr < rule_a_i.end_addr) &&
                     (rule_a_i.idx < NoIndices);

  // Half-open ranges intersect when each starts before the other ends.
  assign overlap_o = (rule_b_i.start_addr < rule_a_i.end_addr) &&
                     (rule_b_i.end_addr > rule_a_i.start_addr);

  assign w_unused_idx_b = |rule_b_i.idx;

endmodule
`default_nettype wire

// File: rtl/addr_map_cfg.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_cfg
// Description : Runtime configuration controller for an address decoder.
//   Rules are written into a shadow array; a commit validates every rule
//   (one per cycle) and then every rule pair (one per cycle) before copying
//   the shadow array atomically into the active map.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o  : rule write handshake (slot, rule)
//   cfg_err_o                : pulse, last accepted write had an illegal slot
//   commit_valid_i/_ready_o  : commit handshake
//   commit_done_o/_err_o     : commit completion pulse and rejection flag
//   err_slot_o               : first failing slot of a rejected commit
//   overlap_o                : active map contains overlapping rules
//   busy_o                   : validation in progress
//   addr_map_o, map_valid_o  : active map and its ever-committed flag
// Revision    : 1.0 - initial release
// ============================================================================
module addr_map_cfg
  import addr_map_cfg_pkg::*;
#(
  parameter  int unsigned NoRules   = 4,
  parameter  int unsigned NoIndices = 4,
  localparam int unsigned SlotWidth = idx_width(NoRules)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [SlotWidth-1:0]        cfg_slot_i,
  input  rule_t                       cfg_rule_i,
  output logic                        cfg_err_o,
  input  logic                        commit_valid_i,
  output logic                        commit_ready_o,
  output logic                        commit_done_o,
  output logic                        commit_err_o,
  output logic [SlotWidth-1:0]        err_slot_o,
  output logic                        overlap_o,
  output logic                        busy_o,
  output rule_t [NoRules-1:0]         addr_map_o,
  output logic                        map_valid_o
);

  state_e                 state_q, state_d;
  logic [SlotWidth-1:0]   i_q, i_d, j_q, j_d;
  logic                   sticky_q, sticky_d;
  rule_t [NoRules-1:0]    shadow_q, shadow_d;
  rule_t [NoRules-1:0]    map_q, map_d;
  logic                   map_valid_q, map_valid_d;
  logic                   overlap_q, overlap_d;
  logic [SlotWidth-1:0]   err_slot_q, err_slot_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   done_q, done_d;
  logic                   cerr_q, cerr_d;

  logic                   w_idle, w_slot_oob, w_rule_ok, w_overlap, w_finish_ok;

  assign w_idle     = (state_q == IDLE);
  assign w_slot_oob = 32'(cfg_slot_i) >= NoRules;

  // One checker, steered by the scan counters.
  addr_map_rule_check #(
    .NoIndices (NoIndices)
  ) u_rule_check (
    .rule_a_i  (shadow_q[i_q]),
    .rule_b_i  (shadow_q[j_q]),
    .rule_ok_o (w_rule_ok),
    .overlap_o (w_overlap)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    sticky_d    = sticky_q;
    shadow_d    = shadow_q;
    map_d       = map_q;
    map_valid_d = map_valid_q;
    overlap_d   = overlap_q;
    err_slot_d  = err_slot_q;
    cfg_err_d   = 1'b0;
    done_d      = 1'b0;
    cerr_d      = 1'b0;
    w_finish_ok = 1'b0;

    case (state_q)
      IDLE: begin
        // A write in the commit cycle lands in shadow before CHK_RULE reads it.
        if (cfg_valid_i) begin
          if (w_slot_oob) cfg_err_d = 1'b1;
          else            shadow_d[cfg_slot_i] = cfg_rule_i;
        end
        if (commit_valid_i) begin
          state_d = CHK_RULE;
          i_d     = '0;
          j_d     = SlotWidth'(1);
        end
      end
      CHK_RULE: begin
        if (!w_rule_ok) begin
          err_slot_d = i_q;
          state_d    = DONE;
          done_d     = 1'b1;
          cerr_d     = 1'b1;
        end else if (i_q == SlotWidth'(NoRules - 1)) begin
          if (NoRules == 1) begin
            w_finish_ok = 1'b1;
          end else begin
            state_d = CHK_PAIR;
            i_d     = '0;
            j_d     = SlotWidth'(1);
          end
        end else begin
          i_d = i_q + SlotWidth'(1);
        end
      end
      CHK_PAIR: begin
        if (w_overlap) sticky_d = 1'b1;
        if (i_q == SlotWidth'(NoRules - 2) && j_q == SlotWidth'(NoRules - 1)) begin
          w_finish_ok = 1'b1;
        end else if (j_q == SlotWidth'(NoRules - 1)) begin
          i_d = i_q + SlotWidth'(1);
          j_d = SlotWidth'(i_q + 2);
        end else begin
          j_d = j_q + SlotWidth'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        sticky_d = 1'b0;
        i_d      = '0;
        j_d      = '0;
      end
      default: state_d = IDLE;
    endcase

    // The active map is loaded on entry to DONE so it is visible with the pulse.
    if (w_finish_ok) begin
      state_d     = DONE;
      done_d      = 1'b1;
      map_d       = shadow_q;
      map_valid_d = 1'b1;
      overlap_d   = sticky_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      sticky_q    <= 1'b0;
      shadow_q    <= '0;
      map_q       <= '0;
      map_valid_q <= 1'b0;
      overlap_q   <= 1'b0;
      err_slot_q  <= '0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
      cerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      sticky_q    <= sticky_d;
      shadow_q    <= shadow_d;
      map_q       <= map_d;
      map_valid_q <= map_valid_d;
      overlap_q   <= overlap_d;
      err_slot_q  <= err_slot_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
      cerr_q      <= cerr_d;
    end
  end

  assign cfg_ready_o    = w_idle;
  assign commit_ready_o = w_idle;
  assign busy_o         = !w_idle;
  assign cfg_err_o      = cfg_err_q;
  assign commit_done_o  = done_q;
  assign commit_err_o   = cerr_q;
  assign err_slot_o     = err_slot_q;
  assign overlap_o      = overlap_q;
  assign addr_map_o     = map_q;
  assign map_valid_o    = map_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_map_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_map_cfg
// Description : Self-checking bench for addr_map_cfg. A four-rule instance
//               runs a table of commit scenarios plus stall, same-cycle and
//               mid-commit reset sequences; a five-rule instance covers
//               out-of-range slot writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_map_cfg;
  import addr_map_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT 1: four rules ----------------
  logic        cfg_valid1 = 1'b0, commit_valid1 = 1'b0;
  logic [1:0]  cfg_slot1 = '0;
  rule_t       cfg_rule1 = '0;
  logic        cfg_ready1, cfg_err1, commit_ready1, done1, cerr1, ovl1, busy1, mv1;
  logic [1:0]  err_slot1;
  rule_t [3:0] map1;

  addr_map_cfg #(.NoRules(4), .NoIndices(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid1), .cfg_ready_o(cfg_ready1), .cfg_slot_i(cfg_slot1),
    .cfg_rule_i(cfg_rule1), .cfg_err_o(cfg_err1),
    .commit_valid_i(commit_valid1), .commit_ready_o(commit_ready1),
    .commit_done_o(done1), .commit_err_o(cerr1), .err_slot_o(err_slot1),
    .overlap_o(ovl1), .busy_o(busy1), .addr_map_o(map1), .map_valid_o(mv1)
  );

  // ---------------- DUT 2: five rules, 3-bit slot ----------------
  logic        cfg_valid2 = 1'b0, commit_valid2 = 1'b0;
  logic [2:0]  cfg_slot2 = '0;
  rule_t       cfg_rule2 = '0;
  logic        cfg_ready2, cfg_err2, commit_ready2, done2, cerr2, ovl2, busy2, mv2;
  logic [2:0]  err_slot2;
  rule_t [4:0] map2;

  addr_map_cfg #(.NoRules(5), .NoIndices(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid2), .cfg_ready_o(cfg_ready2), .cfg_slot_i(cfg_slot2),
    .cfg_rule_i(cfg_rule2), .cfg_err_o(cfg_err2),
    .commit_valid_i(commit_valid2), .commit_ready_o(commit_ready2),
    .commit_done_o(done2), .commit_err_o(cerr2), .err_slot_o(err_slot2),
    .overlap_o(ovl2), .busy_o(busy2), .addr_map_o(map2), .map_valid_o(mv2)
  );

  typedef struct {
    string       name;
    rule_t [3:0] r;
    bit          err;
    int          slot;
    int          lat;
    bit          ovl;
  } vec_t;

  vec_t vecs[9];

  function automatic rule_t mk(input int unsigned idx, input addr_t s, input addr_t e);
    rule_t r;
    r.idx = idx; r.start_addr = s; r.end_addr = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr1(input int slot, input rule_t r);
    @(negedge clk);
    cfg_valid1 = 1'b1; cfg_slot1 = 2'(slot); cfg_rule1 = r;
    @(posedge clk); #1;
    cfg_valid1 = 1'b0;
  endtask

  task automatic wr2(input int slot, input rule_t r);
    @(negedge clk);
    cfg_valid2 = 1'b1; cfg_slot2 = 3'(slot); cfg_rule2 = r;
    @(posedge clk); #1;
    cfg_valid2 = 1'b0;
  endtask

  // Returns #1 into cycle T+1 where T is the commit handshake cycle.
  task automatic start_commit1();
    @(negedge clk);
    commit_valid1 = 1'b1;
    @(posedge clk); #1;
    commit_valid1 = 1'b0;
  endtask

  // Latency is counted in cycles after the handshake cycle T.
  task automatic wait_done1(output int lat);
    int cyc = 1;
    while (!done1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done1) begin
      n_checks++; n_errors++;
      $display("FAIL commit timeout: no done pulse after %0d cycles", cyc);
    end
    lat = cyc;
  endtask

  rule_t [3:0] exp_map;
  rule_t [4:0] exp_map2;
  bit          exp_ovl;
  int          lat;
  rule_t       newr, nr2;
  bit          saw_done;

  initial begin
    vecs[0] = '{"disjoint", {mk(3,'h300,'h400), mk(2,'h200,'h300), mk(1,'h100,'h200), mk(0,'h000,'h100)}, 0, 0, 11, 0};
    vecs[1] = '{"slot2 start>end", {mk(3,'h300,'h400), mk(2,'h300,'h200), mk(1,'h100,'h200), mk(0,'h000,'h100)}, 1, 2, 4, 0};
    vecs[2] = '{"slot1 idx4", {mk(3,'h300,'h400), mk(2,'h200,'h300), mk(4,'h100,'h200), mk(0,'h000,'h100)}, 1, 1, 3, 0};
    vecs[3] = '{"overlap 0-3", {mk(3,'h100,'h300), mk(2,'h500,'h600), mk(1,'h400,'h500), mk(0,'h000,'h200)}, 0, 0, 11, 1};
    vecs[4] = '{"overlap fixed", {mk(3,'h200,'h300), mk(2,'h500,'h600), mk(1,'h400,'h500), mk(0,'h000,'h200)}, 0, 0, 11, 0};
    vecs[5] = '{"slot0 empty range", {mk(9,'h300,'h400), mk(2,'h200,'h300), mk(1,'h100,'h200), mk(0,'h050,'h050)}, 1, 0, 2, 0};
    vecs[6] = '{"unsigned compare", {mk(3,'h7FFFFFFF,'h80000000), mk(2,'h200,'h300), mk(1,'h100,'h200), mk(0,'h000,'h100)}, 0, 0, 11, 0};
    vecs[7] = '{"slot3 idx5", {mk(5,'h300,'h400), mk(2,'h200,'h300), mk(1,'h100,'h200), mk(0,'h000,'h100)}, 1, 3, 5, 0};
    vecs[8] = '{"overlap 1-2", {mk(3,'h300,'h400), mk(2,'h200,'h300), mk(1,'h100,'h250), mk(0,'h000,'h100)}, 0, 0, 11, 1};

    exp_map = '0;
    exp_ovl = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset map_valid", mv1, 0);
    check("reset addr_map", map1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset overlap", ovl1, 0);
    check("reset err_slot", err_slot1, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle cfg_ready", cfg_ready1, 1);
    check("idle commit_ready", commit_ready1, 1);

    // ---- table of commit scenarios ----
    for (int v = 0; v < 9; v++) begin
      for (int s = 0; s < 4; s++) wr1(s, vecs[v].r[s]);
      start_commit1();
      wait_done1(lat);
      check({vecs[v].name, " latency"}, lat, vecs[v].lat);
      check({vecs[v].name, " commit_err"}, cerr1, vecs[v].err);
      if (vecs[v].err) check({vecs[v].name, " err_slot"}, err_slot1, vecs[v].slot);
      else begin
        exp_map = vecs[v].r;
        exp_ovl = vecs[v].ovl;
      end
      check({vecs[v].name, " addr_map"}, map1, exp_map);
      check({vecs[v].name, " map_valid"}, mv1, 1);
      check({vecs[v].name, " overlap"}, ovl1, exp_ovl);
      @(posedge clk); #1;
      check({vecs[v].name, " done single pulse"}, done1, 0);
      check({vecs[v].name, " back to idle"}, busy1, 0);
    end

    // ---- write while busy stalls until after DONE ----
    newr = mk(0, 'h000, 'h010);
    start_commit1();
    cfg_valid1 = 1'b1; cfg_slot1 = 2'd0; cfg_rule1 = newr;
    check("busy during commit", busy1, 1);
    check("cfg_ready low while busy", cfg_ready1, 0);
    check("commit_ready low while busy", commit_ready1, 0);
    wait_done1(lat);
    check("stalled commit latency", lat, 11);
    check("stalled write not in map", map1, vecs[8].r);
    check("cfg_ready low in DONE", cfg_ready1, 0);
    @(posedge clk); #1;
    check("cfg_ready back in idle", cfg_ready1, 1);
    @(posedge clk); #1;
    cfg_valid1 = 1'b0;
    exp_map = vecs[8].r;
    exp_map[0] = newr;
    start_commit1();
    wait_done1(lat);
    check("stalled write committed", map1, exp_map);
    check("stalled write overlap", ovl1, 1);

    // ---- write and commit in the same idle cycle ----
    nr2 = mk(2, 'h260, 'h280);
    @(posedge clk); #1;
    cfg_valid1 = 1'b1; cfg_slot1 = 2'd2; cfg_rule1 = nr2;
    start_commit1();
    cfg_valid1 = 1'b0;
    wait_done1(lat);
    exp_map[2] = nr2;
    check("same-cycle latency", lat, 11);
    check("same-cycle commit_err", cerr1, 0);
    check("same-cycle map", map1, exp_map);
    check("same-cycle overlap cleared", ovl1, 0);

    // ---- reset in cycle T+5 of a commit ----
    @(posedge clk); #1;
    start_commit1();
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done1) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid-commit reset busy", busy1, 0);
    check("mid-commit reset map", map1, 0);
    check("mid-commit reset map_valid", mv1, 0);
    check("mid-commit reset done", done1, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done1) saw_done = 1'b1;
    end
    check("no done after mid-commit reset", saw_done, 0);

    // ---- out-of-range slot writes (five-rule instance) ----
    for (int s = 0; s < 5; s++) begin
      exp_map2[s] = mk(s % 4, addr_t'(s * 'h100), addr_t'((s + 1) * 'h100));
      wr2(s, exp_map2[s]);
    end
    check("legal write no cfg_err", cfg_err2, 0);
    wr2(5, mk(1, 'h0, 'h1000));
    check("slot5 cfg_err pulse", cfg_err2, 1);
    @(posedge clk); #1;
    check("cfg_err single pulse", cfg_err2, 0);
    wr2(7, mk(2, 'h0, 'h1000));
    check("slot7 cfg_err pulse", cfg_err2, 1);
    @(negedge clk);
    commit_valid2 = 1'b1;
    @(posedge clk); #1;
    commit_valid2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("5-rule latency", lat, 16);
    check("5-rule commit_err", cerr2, 0);
    check("5-rule shadow unchanged", map2, exp_map2);
    check("5-rule overlap", ovl2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
